empty_checker: RTL

Read-side pointer and empty-flag controller for the asynchronous FIFO, the counterpart of the write-side full logic. It owns the read pointer in binary and Gray form and drives the RAM read address. It synchronizes the write-domain Gray pointer into the read clock domain through a two-flop stage. From that synchronized pointer it produces a registered empty flag, a fill level, an almost-empty flag and an underflow indication. It sits between the FIFO memory's read port and the read-domain consumer, and exports its Gray pointer to the write side.

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/empty_checker.sv | 98 +++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - async FIFO pointer type, default depth and Gray-code helpers
package async_fifo_pkg;

  localparam int ADDR_SIZE_DEFAULT = 4;

  typedef logic [ADDR_SIZE_DEFAULT:0] ptr_t;

  // Operands are zero-extended to 32 bits so one helper serves every pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    logic        acc;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterized two-flop synchronizer, synchronous active-high reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/empty_checker.sv
// rtl/empty_checker.sv - async FIFO read pointer and empty flag; ASYNC_FIFO_RD_LEVEL_EN adds level/almost-empty
module empty_checker
  import async_fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  ,
  parameter int AE_THRESH = 2
`endif
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_en,
  input  logic [ADDR_SIZE:0]   w_ptr_gray,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_ptr_gray,
  output logic                 r_empty,
  output logic                 r_underflow
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_SIZE:0]   r_level,
  output logic                 r_almost_empty
`endif
);

  localparam int PW = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] w_gray_sync;
  logic [ADDR_SIZE:0] r_ptr_bin_q, r_ptr_bin_d;
  logic [ADDR_SIZE:0] r_ptr_gray_q, r_ptr_gray_d;
  logic               r_empty_q, r_empty_d;
  logic               r_underflow_q, r_underflow_d;
  logic               rd_accept;

  sync_2ff #(.WIDTH(PW)) u_w_sync (
    .clk (r_clk),
    .rst (r_rst),
    .d   (w_ptr_gray),
    .q   (w_gray_sync)
  );

  // Compare the post-read pointer against the current sync2 so a last-entry read sets empty with no bubble.
  always_comb begin
    rd_accept     = r_en && !r_empty_q;
    r_ptr_bin_d   = r_ptr_bin_q + {{ADDR_SIZE{1'b0}}, rd_accept};
    r_ptr_gray_d  = PW'(bin2gray(32'(r_ptr_bin_d)));
    r_empty_d     = (r_ptr_gray_d == w_gray_sync);
    r_underflow_d = r_en && r_empty_q;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_ptr_bin_q   <= '0;
      r_ptr_gray_q  <= '0;
      r_empty_q     <= 1'b1;
      r_underflow_q <= 1'b0;
    end else begin
      r_ptr_bin_q   <= r_ptr_bin_d;
      r_ptr_gray_q  <= r_ptr_gray_d;
      r_empty_q     <= r_empty_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign r_addr      = r_ptr_bin_q[ADDR_SIZE-1:0];
  assign r_ptr_gray  = r_ptr_gray_q;
  assign r_empty     = r_empty_q;
  assign r_underflow = r_underflow_q;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  localparam logic [ADDR_SIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ADDR_SIZE:0] w_bin_sync;
  logic [ADDR_SIZE:0] r_level_q, r_level_d;
  logic               r_almost_empty_q, r_almost_empty_d;

  // Modular subtraction yields 0..2^ADDR_SIZE because the pointers carry a wrap bit.
  always_comb begin
    w_bin_sync       = PW'(gray2bin(32'(w_gray_sync)));
    r_level_d        = w_bin_sync - r_ptr_bin_d;
    r_almost_empty_d = (r_level_d <= AE_LIMIT);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_level_q        <= '0;
      r_almost_empty_q <= 1'b1;
    end else begin
      r_level_q        <= r_level_d;
      r_almost_empty_q <= r_almost_empty_d;
    end
  end

  assign r_level        = r_level_q;
  assign r_almost_empty = r_almost_empty_q;
`endif

endmodule
